// File: rtl/pu_feeder_pkg.sv
// Shared types and constants for the PU window feeder.
// Holds the feeder state encoding, the window size and the default data width.
package pu_feeder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      SLIDE = 2'd2
   } state_t;

   localparam int WIN        = 4;
   localparam int DW_DEFAULT = 32;

endpackage

// File: rtl/valid_delay.sv
// Synchronous-reset shift register that carries {valid, last} alongside the PU pipeline.
// The delay line is cleared by reset, so windows issued before reset never produce a result.
module valid_delay #(
   parameter int DEPTH = 2,
   parameter int W     = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] vld_p [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) vld_p[i] <= '0;
      end else begin
         vld_p[0] <= din;
         for (int i = 1; i < DEPTH; i++) vld_p[i] <= vld_p[i-1];
      end
   end

   assign dout = vld_p[DEPTH-1];

endmodule

// File: rtl/pu_window_feeder.sv
// Builds a 4-sample sliding window from a valid/ready stream and feeds it, with a small
// weight file, to the 4-input PU; out_valid/out_last are issue delayed to match the PU latency.
module pu_window_feeder
   import pu_feeder_pkg::*;
#(
   parameter int DW         = DW_DEFAULT,
   parameter int STRIDE     = 1,
   parameter int PU_LATENCY = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          w_we,
   input  logic [1:0]    w_addr,
   input  logic [DW-1:0] w_data,
   output logic          w_err,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   input  logic          in_last,
   output logic          in_ready,
   output logic [DW-1:0] a1,
   output logic [DW-1:0] a2,
   output logic [DW-1:0] a3,
   output logic [DW-1:0] a4,
   output logic [DW-1:0] w1,
   output logic [DW-1:0] w2,
   output logic [DW-1:0] w3,
   output logic [DW-1:0] w4,
   output logic          issue,
   output logic          drop,
   output logic          out_valid,
   output logic          out_last
);

   state_t        state, next_state;
   logic [2:0]    fill_cnt, fill_nxt;
   logic [2:0]    stride_cnt, stride_nxt;
   logic          accept, win_done, last_issue, last_drop;
   logic          issue_last;
   logic [DW-1:0] wreg [4];

   assign in_ready = (state != IDLE);
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      fill_nxt   = fill_cnt;
      stride_nxt = stride_cnt;
      win_done   = 1'b0;
      last_issue = 1'b0;
      last_drop  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = FILL;
               fill_nxt   = '0;
            end
         end
         FILL: begin
            if (accept) begin
               if (fill_cnt == 3'(WIN - 1)) begin
                  win_done   = 1'b1;
                  next_state = SLIDE;
                  stride_nxt = '0;
               end else begin
                  fill_nxt = fill_cnt + 3'd1;
               end
            end
         end
         SLIDE: begin
            if (accept) begin
               if (stride_cnt == 3'(STRIDE - 1)) begin
                  win_done   = 1'b1;
                  stride_nxt = '0;
               end else begin
                  stride_nxt = stride_cnt + 3'd1;
               end
            end
         end
         default: next_state = IDLE;
      endcase
      // A frame-ending sample either completes a window or leaves a partial one behind.
      if (accept && in_last) begin
         next_state = IDLE;
         last_issue = win_done;
         last_drop  = ~win_done;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fill_cnt   <= '0;
         stride_cnt <= '0;
         issue      <= 1'b0;
         issue_last <= 1'b0;
         drop       <= 1'b0;
         w_err      <= 1'b0;
         a1         <= '0;
         a2         <= '0;
         a3         <= '0;
         a4         <= '0;
         for (int i = 0; i < 4; i++) wreg[i] <= '0;
      end else begin
         fill_cnt   <= fill_nxt;
         stride_cnt <= stride_nxt;
         issue      <= win_done;
         issue_last <= last_issue;
         drop       <= last_drop;
         w_err      <= w_we && (state != IDLE);
         if (accept) begin
            a1 <= a2;
            a2 <= a3;
            a3 <= a4;
            a4 <= in_data;
         end
         if (w_we && (state == IDLE)) wreg[w_addr] <= w_data;
      end
   end

   assign w1 = wreg[0];
   assign w2 = wreg[1];
   assign w3 = wreg[2];
   assign w4 = wreg[3];

   // Issue stage boundary: {issue, issue_last} ride alongside the PU multiply/add registers.
   valid_delay #(
      .DEPTH (PU_LATENCY),
      .W     (2)
   ) u_valid_delay (
      .clk  (clk),
      .rst  (rst),
      .din  ({issue, issue_last}),
      .dout ({out_valid, out_last})
   );

endmodule
